// File: rtl/demux_1to4_collector.sv
// demux_1to4_collector
// Registered 1-to-4 demultiplexer/collector. Single-lane words are steered into
// one of four lane registers (by `sel` or an internal round-robin counter).
// Once every lane has been written, the assembled 4-lane word is offered on a
// valid/ready handshake and the input side stalls until it is taken.
module demux_1to4_collector #(
    parameter int WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in,
    input  logic [1:0]           sel,
    input  logic                 auto,
    output logic [4*WIDTH-1:0]   out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           filled
);

    typedef enum logic {
        FILL = 1'b0,   // collecting lanes, input side open
        FULL = 1'b1    // word complete, waiting for the consumer
    } state_t;

    state_t                    state_q, state_d;
    logic [1:0]                cnt_q, cnt_d;
    logic [3:0]                filled_q, filled_d;
    logic [3:0][WIDTH-1:0]     lanes_q, lanes_d;
    logic [1:0]                lane;

    // Lane chosen for the current write: round-robin counter or explicit select.
    assign lane = auto ? cnt_q : sel;

    // Next-state logic: lane writes while filling, release on consumer handshake.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it
        // unassigned; that is what keeps this block free of inferred latches.
        state_d  = state_q;
        cnt_d    = cnt_q;
        filled_d = filled_q;
        lanes_d  = lanes_q;

        unique case (state_q)
            FILL: begin
                if (in_valid) begin
                    lanes_d[lane]  = in;
                    filled_d[lane] = 1'b1;
                    if (auto) begin
                        cnt_d = cnt_q + 2'd1;   // wraps 3 -> 0 naturally
                    end
                    // Completion looks at the mask including this write, so the
                    // word is offered the cycle right after the last lane lands.
                    if (filled_d == 4'b1111) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                // Input is ignored here; lanes and mask stay frozen until taken.
                if (out_ready) begin
                    state_d  = FILL;
                    filled_d = 4'b0000;
                    cnt_d    = 2'd0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // State register with synchronous reset that overrides every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the lane registers are reset too, since `out` must read
            // zero after reset rather than whatever the last word left behind.
            state_q  <= FILL;
            cnt_q    <= 2'd0;
            filled_q <= 4'b0000;
            lanes_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // computed for this edge, independent of statement order.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            filled_q <= filled_d;
            lanes_q  <= lanes_d;
        end
    end

    // Outputs decoded from registered state only; no input-to-handshake path.
    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == FULL);
    assign out       = lanes_q;
    assign filled    = filled_q;

endmodule

// File: tb/tb_demux_1to4_collector.sv
// Testbench for demux_1to4_collector (WIDTH=1). Directed stimulus; completed
// words are predicted into a queue and checked by an independent monitor that
// fires on each out_valid/out_ready handshake.
module tb_demux_1to4_collector;

    localparam int WIDTH = 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   din;
    logic [1:0]         sel;
    logic               auto;
    logic [4*WIDTH-1:0] dout;
    logic               out_valid;
    logic               out_ready;
    logic [3:0]         filled;

    int vectors    = 0;
    int miscompares = 0;

    logic [3:0] exp_q[$];

    demux_1to4_collector #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (din),
        .sel       (sel),
        .auto      (auto),
        .out       (dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .filled    (filled)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word for a single edge, then drop in_valid.
    task automatic write(input logic a, input logic [1:0] s, input logic d);
        in_valid = 1'b1;
        auto     = a;
        sel      = s;
        din      = d;
        tick();
        in_valid = 1'b0;
    endtask

    // One-edge consumer handshake.
    task automatic accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Monitor: compare each word the DUT hands over against the prediction.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL word_unexpected: got %0h with no prediction", dout);
                end else begin
                    check("word_out", 32'(dout), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        din       = '0;
        sel       = 2'd0;
        auto      = 1'b0;
        out_ready = 1'b0;

        // Reset state.
        tick();
        tick();
        check("rst_out",       32'(dout),      32'h0);
        check("rst_filled",    32'(filled),    32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_in_ready",  32'(in_ready),  32'h1);
        reset = 1'b0;

        // Auto fill 1,0,1,1 -> lanes {3,2,1,0} = 1,1,0,1.
        write(1'b1, 2'd0, 1'b1); check("auto_filled0", 32'(filled), 32'h1);
        write(1'b1, 2'd0, 1'b0); check("auto_filled1", 32'(filled), 32'h3);
        write(1'b1, 2'd0, 1'b1); check("auto_filled2", 32'(filled), 32'h7);
        check("auto_not_valid_yet", 32'(out_valid), 32'h0);
        exp_q.push_back(4'b1101);
        write(1'b1, 2'd0, 1'b1); check("auto_filled3", 32'(filled), 32'hF);
        check("auto_out",       32'(dout),      32'hD);
        check("auto_out_valid", 32'(out_valid), 32'h1);
        check("auto_in_ready",  32'(in_ready),  32'h0);
        accept();
        check("acc_out_valid", 32'(out_valid), 32'h0);
        check("acc_filled",    32'(filled),    32'h0);
        check("acc_in_ready",  32'(in_ready),  32'h1);

        // Counter restarted: next auto write of 0 lands in lane 0 (1101 -> 1100).
        write(1'b1, 2'd0, 1'b0);
        check("cnt_restart_filled", 32'(filled), 32'h1);
        check("cnt_restart_out",    32'(dout),   32'hC);

        // out_ready while filling has no effect.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("rdy_in_fill_filled", 32'(filled),    32'h1);
        check("rdy_in_fill_valid",  32'(out_valid), 32'h0);

        // Addressed fill with overwrite: 3<-1, 1<-1, 3<-0, 0<-1, 2<-1.
        write(1'b0, 2'd3, 1'b1);
        write(1'b0, 2'd1, 1'b1);
        write(1'b0, 2'd3, 1'b0);
        check("addr_overwrite_filled", 32'(filled), 32'hB);
        write(1'b0, 2'd0, 1'b1);
        check("addr_4th_filled", 32'(filled),    32'hB);
        check("addr_4th_valid",  32'(out_valid), 32'h0);
        exp_q.push_back(4'b0111);
        write(1'b0, 2'd2, 1'b1);
        check("addr_5th_valid", 32'(out_valid), 32'h1);
        check("addr_5th_out",   32'(dout),      32'h7);

        // Backpressure: input presented while FULL must be dropped.
        in_valid = 1'b1;
        din      = 1'b0;
        auto     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_out",       32'(dout),      32'h7);
            check("bp_in_ready",  32'(in_ready),  32'h0);
            check("bp_filled",    32'(filled),    32'hF);
            check("bp_out_valid", 32'(out_valid), 32'h1);
        end
        in_valid = 1'b0;
        accept();
        check("bp_release_in_ready", 32'(in_ready), 32'h1);

        // Mode mix: auto lanes 0,1; sel=3; auto again lands in lane 2.
        write(1'b1, 2'd0, 1'b1);
        write(1'b1, 2'd0, 1'b0);
        write(1'b0, 2'd3, 1'b1);
        check("mix_filled_sel", 32'(filled), 32'hB);
        exp_q.push_back(4'b1101);
        write(1'b1, 2'd0, 1'b1);
        check("mix_filled_done", 32'(filled),    32'hF);
        check("mix_out",         32'(dout),      32'hD);
        check("mix_out_valid",   32'(out_valid), 32'h1);
        accept();

        // Reset mid-fill.
        write(1'b1, 2'd0, 1'b1);
        write(1'b1, 2'd0, 1'b1);
        check("mid_pre_filled", 32'(filled), 32'h3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_filled",   32'(filled),    32'h0);
        check("mid_rst_out",      32'(dout),      32'h0);
        check("mid_rst_in_ready", 32'(in_ready),  32'h1);
        check("mid_rst_valid",    32'(out_valid), 32'h0);
        write(1'b1, 2'd0, 1'b1);
        check("mid_post_filled", 32'(filled), 32'h1);
        check("mid_post_out",    32'(dout),   32'h1);

        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
